// File: rtl/aec_job_arbiter.sv
// Round-robin front end for a single AEC expression evaluator: collects one
// '='-terminated job per grant, replays it gap-free, and returns the tagged result.
module aec_job_arbiter #(
    parameter int N_REQ     = 2,
    parameter int ID_W      = 1,
    parameter int BUF_DEPTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_char,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_aec_ready,
    output logic [7:0]         o_aec_ascii,
    input  logic               i_aec_valid,
    input  logic [6:0]         i_aec_result,
    output logic               o_rsp_valid,
    output logic [ID_W-1:0]    o_rsp_id,
    output logic [6:0]         o_rsp_result,
    output logic               o_rsp_err
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_STREAM, S_WAIT, S_RESP, S_COOL
    } state_t;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_rr, r_gnt;
    logic [CNT_W-1:0]   r_cnt, r_idx;
    logic [TMR_W-1:0]   r_tmr;
    logic [7:0]         r_buf [BUF_DEPTH];
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_aec_ready;
    logic [7:0]         r_aec_ascii;
    logic               r_rsp_valid, r_rsp_err;
    logic [ID_W-1:0]    r_rsp_id;
    logic [6:0]         r_rsp_result;

    logic [2*N_REQ-1:0] w_dbl;
    logic               w_found;
    int                 w_off, w_sum, w_sum2;
    logic [ID_W-1:0]    w_pick, w_rr_nxt, w_gnt_nxt;
    logic [N_REQ-1:0]   w_oh;
    logic [7:0]         w_char;
    logic               w_acc, w_eq, w_rsp_err;
    logic [6:0]         w_rsp_res;

    // Rotate the request vector so the search always starts at the rr pointer.
    always_comb begin
        w_dbl   = {i_req_valid, i_req_valid} >> r_rr;
        w_found = 1'b0;
        w_off   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_sum = int'(r_rr) + w_off;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        w_sum2 = w_sum + 1;
        if (w_sum2 >= N_REQ) w_sum2 = 0;
        w_pick   = ID_W'(w_sum);
        w_rr_nxt = ID_W'(w_sum2);
    end

    always_comb begin
        w_gnt_nxt = (r_state == S_IDLE) ? w_pick : r_gnt;
        w_char    = '0;
        w_oh      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == r_gnt)     w_char  = i_req_char[8*k +: 8];
            if (ID_W'(k) == w_gnt_nxt) w_oh[k] = 1'b1;
        end
        w_acc = |(i_req_valid & r_req_ready);
        w_eq  = (w_char == 8'h3D);
    end

    always_comb begin
        w_next    = r_state;
        w_rsp_err = 1'b1;
        w_rsp_res = '0;
        case (r_state)
            S_IDLE:   if (|i_req_valid) w_next = S_LOAD;
            S_LOAD: begin
                if (w_acc) begin
                    if (w_eq)                                w_next = (r_cnt == '0) ? S_RESP : S_STREAM;
                    else if (r_cnt == CNT_W'(BUF_DEPTH - 1)) w_next = S_DRAIN;
                end
            end
            S_DRAIN:  if (w_acc && w_eq) w_next = S_RESP;
            S_STREAM: if (r_idx == r_cnt - CNT_W'(1)) w_next = S_WAIT;
            S_WAIT: begin
                if (i_aec_valid) begin
                    w_next    = S_RESP;
                    w_rsp_err = 1'b0;
                    w_rsp_res = i_aec_result;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:   w_next = S_COOL;
            S_COOL:   if (r_tmr == TMR_W'(1)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_tmr        <= '0;
            r_req_ready  <= '0;
            r_aec_ready  <= 1'b0;
            r_aec_ascii  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (|i_req_valid) begin
                    r_gnt <= w_pick;
                    r_rr  <= w_rr_nxt;
                end
                S_LOAD:   if (w_acc) r_cnt <= r_cnt + CNT_W'(1);
                S_STREAM: begin
                    r_idx <= r_idx + CNT_W'(1);
                    r_tmr <= '0;
                end
                S_WAIT:   r_tmr <= r_tmr + TMR_W'(1);
                S_RESP:   r_tmr <= '0;
                S_COOL: begin
                    r_tmr <= r_tmr + TMR_W'(1);
                    if (r_tmr == TMR_W'(1)) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_tmr <= '0;
                    end
                end
                default: ;
            endcase
            r_req_ready <= (w_next == S_LOAD || w_next == S_DRAIN) ? w_oh : '0;
            // Evaluator port trails the STREAM state by one cycle (registered replay).
            r_aec_ready <= (r_state == S_STREAM);
            r_aec_ascii <= (r_state == S_STREAM) ? r_buf[r_idx[IDX_W-1:0]] : 8'h00;
            r_rsp_valid  <= (w_next == S_RESP);
            r_rsp_id     <= (w_next == S_RESP) ? r_gnt : '0;
            r_rsp_err    <= (w_next == S_RESP) ? w_rsp_err : 1'b0;
            r_rsp_result <= (w_next == S_RESP) ? w_rsp_res : '0;
        end
    end

    // Storage needs no reset: only entries below r_cnt are ever replayed.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD && w_acc) r_buf[r_cnt[IDX_W-1:0]] <= w_char;
    end

    assign o_req_ready  = r_req_ready;
    assign o_aec_ready  = r_aec_ready;
    assign o_aec_ascii  = r_aec_ascii;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_aec_job_arbiter.sv
// Directed bench for aec_job_arbiter: per-requester byte sources, a delayed-answer
// evaluator model, and a negedge monitor that logs stream and response activity.
module tb_aec_job_arbiter;
    localparam int TIMEOUT = 64;

    logic        clk, rst;
    logic        v0, v1;
    logic [7:0]  c0, c1;
    logic [1:0]  req_valid;
    logic [15:0] req_char;
    logic [1:0]  req_ready;
    logic        aec_ready, aec_valid, rsp_valid, rsp_err;
    logic [7:0]  aec_ascii;
    logic [6:0]  aec_result, rsp_result;
    logic [0:0]  rsp_id;

    assign req_valid = {v1, v0};
    assign req_char  = {c1, c0};

    aec_job_arbiter #(.N_REQ(2), .ID_W(1), .BUF_DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_char(req_char), .o_req_ready(req_ready),
        .o_aec_ready(aec_ready), .o_aec_ascii(aec_ascii),
        .i_aec_valid(aec_valid), .i_aec_result(aec_result),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_result(rsp_result), .o_rsp_err(rsp_err)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] q0[$], q1[$];
    int gap0 = 0, gap1 = 0, g0 = 0, g1 = 0;
    logic a0, a1;
    int eval_en = 1, eval_delay = 3, cd = 0;
    logic [6:0] eval_res = 0;

    logic [7:0] st_chr[$];
    int         st_cyc[$];
    int         r_idq[$], r_resq[$], r_errq[$], r_cycq[$];
    int         last_acc = 0, av_cyc = 0;
    logic       both_rdy = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        v0 = 0; c0 = 0;
        forever begin
            @(negedge clk); a0 = v0 & req_ready[0];
            @(posedge clk); #1;
            if (a0 && q0.size() > 0) begin q0.delete(0); g0 = gap0; end
            if (g0 > 0) begin v0 = 0; g0--; end
            else if (q0.size() > 0) begin v0 = 1; c0 = q0[0]; end
            else v0 = 0;
        end
    end

    initial begin
        v1 = 0; c1 = 0;
        forever begin
            @(negedge clk); a1 = v1 & req_ready[1];
            @(posedge clk); #1;
            if (a1 && q1.size() > 0) begin q1.delete(0); g1 = gap1; end
            if (g1 > 0) begin v1 = 0; g1--; end
            else if (q1.size() > 0) begin v1 = 1; c1 = q1[0]; end
            else v1 = 0;
        end
    end

    // Evaluator model: answers eval_res eval_delay cycles after it sees '='.
    initial begin
        aec_valid = 0; aec_result = 0;
        forever begin
            @(negedge clk);
            if (aec_ready && aec_ascii == 8'h3D && eval_en != 0) cd = eval_delay;
            @(posedge clk); #1;
            aec_valid = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin aec_valid = 1; aec_result = eval_res; end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (aec_ready) begin st_chr.push_back(aec_ascii); st_cyc.push_back(cyc); end
        if (rsp_valid) begin
            r_idq.push_back(int'(rsp_id)); r_resq.push_back(int'(rsp_result));
            r_errq.push_back(int'(rsp_err)); r_cycq.push_back(cyc);
        end
        if (|(req_valid & req_ready)) last_acc = cyc;
        if (req_ready == 2'b11) both_rdy = 1;
        if (aec_valid) av_cyc = cyc;
    end

    task automatic push(input int r, input string s);
        for (int i = 0; i < s.len(); i++)
            if (r == 0) q0.push_back(s[i]); else q1.push_back(s[i]);
    endtask

    task automatic clr_logs();
        st_chr.delete(); st_cyc.delete();
        r_idq.delete(); r_resq.delete(); r_errq.delete(); r_cycq.delete();
        both_rdy = 0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget && r_idq.size() < n; i++) @(negedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if ({aec_ready, aec_ascii} !== 9'h0) begin errors++; $display("FAIL reset_aec got %b/%h want 0/00", aec_ready, aec_ascii); end
        checks++; if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== 10'h0) begin
            errors++; $display("FAIL reset_rsp got v%b id%0d r%0d e%b want all 0", rsp_valid, rsp_id, rsp_result, rsp_err); end
        do_reset();
    endtask

    task automatic test_basic();
        clr_logs(); eval_res = 7;
        push(0, "3+4=");
        wait_rsp(1, 100);
        checks++; if (st_chr.size() != 4) begin errors++; $display("FAIL t1_stream_len got %0d want 4", st_chr.size()); end
        else begin
            checks++; if ({st_chr[0], st_chr[1], st_chr[2], st_chr[3]} !== 32'h332B343D) begin
                errors++; $display("FAIL t1_stream_chars got %h%h%h%h want 332B343D", st_chr[0], st_chr[1], st_chr[2], st_chr[3]); end
            checks++; if (st_cyc[3] - st_cyc[0] != 3) begin errors++; $display("FAIL t1_contiguous got span %0d want 3", st_cyc[3] - st_cyc[0]); end
            checks++; if (st_cyc[0] - last_acc != 2) begin errors++; $display("FAIL t1_first_char_latency got %0d want 2", st_cyc[0] - last_acc); end
        end
        checks++; if (r_idq.size() != 1) begin errors++; $display("FAIL t1_rsp_count got %0d want 1", r_idq.size()); end
        else begin
            checks++; if (r_idq[0] != 0 || r_resq[0] != 7 || r_errq[0] != 0) begin
                errors++; $display("FAIL t1_rsp got id%0d r%0d e%0d want id0 r7 e0", r_idq[0], r_resq[0], r_errq[0]); end
            checks++; if (r_cycq[0] - av_cyc != 1) begin errors++; $display("FAIL t1_rsp_latency got %0d want 1", r_cycq[0] - av_cyc); end
        end
    endtask

    task automatic test_round_robin();
        int exp_id[4] = '{0, 1, 0, 1};
        do_reset(); clr_logs(); eval_res = 3;
        push(0, "1+2="); push(0, "1+2=");
        push(1, "2+1="); push(1, "2+1=");
        wait_rsp(4, 400);
        checks++; if (r_idq.size() != 4) begin errors++; $display("FAIL t2_rsp_count got %0d want 4", r_idq.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (r_idq[i] != exp_id[i] || r_errq[i] != 0) begin
                errors++; $display("FAIL t2_order[%0d] got id%0d e%0d want id%0d e0", i, r_idq[i], r_errq[i], exp_id[i]); end
        end
        checks++; if (both_rdy !== 1'b0) begin errors++; $display("FAIL t2_ready_exclusive got %b want 0", both_rdy); end
        checks++; if (st_chr.size() != 16) begin errors++; $display("FAIL t2_stream_total got %0d want 16", st_chr.size()); end
    endtask

    task automatic test_gaps();
        logic [63:0] got;
        clr_logs(); eval_res = 20; gap1 = 3;
        push(1, "(2+3)*4=");
        wait_rsp(1, 200);
        gap1 = 0;
        checks++; if (st_chr.size() != 8) begin errors++; $display("FAIL t3_stream_len got %0d want 8", st_chr.size()); end
        else begin
            got = '0;
            for (int i = 0; i < 8; i++) got = {got[55:0], st_chr[i]};
            checks++; if (got !== 64'h28322B33292A343D) begin errors++; $display("FAIL t3_stream_chars got %h want 28322B33292A343D", got); end
            checks++; if (st_cyc[7] - st_cyc[0] != 7) begin errors++; $display("FAIL t3_contiguous got span %0d want 7", st_cyc[7] - st_cyc[0]); end
        end
        checks++; if (r_idq.size() != 1 || r_idq[0] != 1 || r_resq[0] != 20 || r_errq[0] != 0) begin
            errors++; $display("FAIL t3_rsp got n%0d id%0d r%0d want n1 id1 r20 e0", r_idq.size(),
                r_idq.size() > 0 ? r_idq[0] : -1, r_resq.size() > 0 ? r_resq[0] : -1); end
    endtask

    task automatic test_overflow();
        clr_logs();
        push(0, "1234567890abcdef5=");
        wait_rsp(1, 200);
        checks++; if (st_chr.size() != 0) begin errors++; $display("FAIL t4_drain_streamed got %0d want 0", st_chr.size()); end
        checks++; if (r_idq.size() != 1 || r_idq[0] != 0 || r_resq[0] != 0 || r_errq[0] != 1) begin
            errors++; $display("FAIL t4_rsp got n%0d e%0d want n1 id0 r0 e1", r_idq.size(), r_errq.size() > 0 ? r_errq[0] : -1); end
        // Exactly BUF_DEPTH chars with '=' last still fits.
        clr_logs(); eval_res = 5;
        push(0, "123456789012345=");
        wait_rsp(1, 200);
        checks++; if (st_chr.size() != 16) begin errors++; $display("FAIL t4_full_len got %0d want 16", st_chr.size()); end
        checks++; if (r_idq.size() != 1 || r_resq[0] != 5 || r_errq[0] != 0) begin
            errors++; $display("FAIL t4_full_rsp got n%0d r%0d want n1 r5 e0", r_idq.size(), r_resq.size() > 0 ? r_resq[0] : -1); end
    endtask

    task automatic test_errors();
        clr_logs();
        push(1, "=");
        wait_rsp(1, 100);
        checks++; if (st_chr.size() != 0) begin errors++; $display("FAIL t5_lone_streamed got %0d want 0", st_chr.size()); end
        checks++; if (r_idq.size() != 1 || r_idq[0] != 1 || r_resq[0] != 0 || r_errq[0] != 1) begin
            errors++; $display("FAIL t5_lone_rsp got n%0d e%0d want n1 id1 r0 e1", r_idq.size(), r_errq.size() > 0 ? r_errq[0] : -1); end
        clr_logs(); eval_en = 0;
        push(0, "1=");
        wait_rsp(1, 200);
        eval_en = 1;
        checks++; if (r_idq.size() != 1 || st_chr.size() != 2) begin
            errors++; $display("FAIL t5_timeout_seen got rsp%0d chars%0d want 1/2", r_idq.size(), st_chr.size()); end
        else begin
            checks++; if (r_errq[0] != 1 || r_resq[0] != 0) begin errors++; $display("FAIL t5_timeout_err got e%0d r%0d want e1 r0", r_errq[0], r_resq[0]); end
            checks++; if (r_cycq[0] - st_cyc[1] != TIMEOUT) begin
                errors++; $display("FAIL t5_timeout_cycles got %0d want %0d", r_cycq[0] - st_cyc[1], TIMEOUT); end
        end
    endtask

    task automatic test_reset_midjob();
        int n;
        clr_logs(); eval_res = 81;
        push(0, "9*9=");
        n = 0;
        while (st_chr.size() < 2 && n < 100) begin @(negedge clk); n++; end
        checks++; if (st_chr.size() < 2) begin errors++; $display("FAIL t6_stream_start got %0d chars want >=2", st_chr.size()); end
        @(posedge clk); #2 rst = 1;
        #1;
        checks++; if (aec_ready !== 1'b0 || aec_ascii !== 8'h00) begin
            errors++; $display("FAIL t6_abort got %b/%h want 0/00", aec_ready, aec_ascii); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (r_idq.size() != 0) begin errors++; $display("FAIL t6_no_rsp got %0d want 0", r_idq.size()); end
        clr_logs();
        push(0, "9*9="); push(1, "8=");
        wait_rsp(2, 300);
        checks++; if (r_idq.size() != 2) begin errors++; $display("FAIL t6_rsp_count got %0d want 2", r_idq.size()); end
        else begin
            checks++; if (r_idq[0] != 0 || r_resq[0] != 81 || r_errq[0] != 0) begin
                errors++; $display("FAIL t6_first got id%0d r%0d e%0d want id0 r81 e0", r_idq[0], r_resq[0], r_errq[0]); end
            checks++; if (r_idq[1] != 1) begin errors++; $display("FAIL t6_second got id%0d want 1", r_idq[1]); end
        end
    endtask

    initial begin
        rst = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_gaps();
        test_overflow();
        test_errors();
        test_reset_midjob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
